comparador_serial_izq_der: RTL
==============================

// Module: comparador_serial_izq_der
// PURPOSE
//  Bit-serial magnitude comparator that scans two unsigned words from left to right (MSB first).
//  It is the opposite scan direction to the combinational right-to-left comparator cell chain.
//  Words are loaded in parallel, compared one bit per clock, and the result is reported as
//  menor/igual/mayor with a start/valid handshake.
//  Sits beside the iterative comparator as its low-area, multi-cycle counterpart.
// PARAMETERS
//  WIDTH       8   word width in bits, >= 2
//  EARLY_EXIT  1   1: finish at first differing bit; 0: always scan all WIDTH bits
// PORTS
//  clk     in   1                     rising-edge clock
//  rst     in   1                     synchronous reset, active-high
//  start   in   1                     request; sampled only in IDLE or DONE
//  A       in   WIDTH                 operand A, captured on accepted start
//  B       in   WIDTH                 operand B, captured on accepted start
//  busy    out  1                     high while in COMPARE
//  valid   out  1                     one-cycle pulse: result flags updated
//  menor   out  1                     A < B, held until next accepted start
//  igual   out  1                     A == B, held until next accepted start
//  mayor   out  1                     A > B, held until next accepted start
//  ciclos  out  $clog2(WIDTH+1)       bits examined for the last result, held
// BEHAVIOUR
//  Reset (rst=1 at edge, any state incl. mid-COMPARE): state IDLE; busy, valid, menor, igual,
//   mayor = 0; ciclos = 0; shift regs, counter and internal relation (rel) cleared to EQ.
//   Any operation in progress is discarded and produces no valid pulse.
//  FSM states: IDLE, COMPARE, DONE.
//  IDLE/DONE + start=1:
//   - load a_sh<=A, b_sh<=B; cnt<=0; rel<=EQ.
//   - clear menor/igual/mayor to 0; go to COMPARE.
//  IDLE + start=0: stay.
//  DONE + start=0: go to IDLE.
//  COMPARE, each cycle:
//   - examine a=a_sh[WIDTH-1], b=b_sh[WIDTH-1].
//   - if rel==EQ and a!=b, then rel<=(a ? GT : LT); a decided rel never changes.
//   - shift a_sh and b_sh left by 1; cnt<=cnt+1.
//   - leave to DONE when cnt+1==WIDTH, or (EARLY_EXIT and a!=b and rel==EQ).
//   - start is ignored while in COMPARE; A and B may change freely.
//  Entry to DONE, same edge:
//   - menor=(rel_next==LT), mayor=(rel_next==GT), igual=(rel_next==EQ); ciclos=cnt+1.
//   - valid=1 for exactly the DONE cycle; busy=0 in DONE.
//  Exactly one of menor/igual/mayor is 1 after any valid; all are 0 between start and valid.
//  Latency, with start sampled at edge 0:
//   - valid high in cycle k+1 after that edge.
//   - k = WIDTH if EARLY_EXIT=0 or A==B; otherwise k = 1-based MSB index of the first differing bit.
//  Back-to-back: start=1 in the DONE cycle is accepted; the next cycle is COMPARE
//   (valid still pulses only that one DONE cycle).
// TESTING (WIDTH=8, EARLY_EXIT=1 unless stated)
//  A=0x05, B=0x09, start 1 cycle:
//   -> busy for 5 cycles; valid in cycle 6; menor=1, igual=0, mayor=0; ciclos=5.
//  A=0x80, B=0x7F:
//   -> valid in cycle 2; mayor=1; ciclos=1.
//  A=B=0xA5:
//   -> valid in cycle 9; igual=1; ciclos=8.
//  Same A=B=0xA5 with EARLY_EXIT=0:
//   -> also 9 cycles.
//  EARLY_EXIT=0, A=0x80, B=0x7F:
//   -> valid in cycle 9; mayor=1; ciclos=8.
//  Start A=0x01, B=0x02; pulse start with A=0xFF during COMPARE:
//   -> ignored; result menor=1, ciclos=7.
//  rst=1 at COMPARE cycle 3:
//   -> next cycle all outputs 0, IDLE, no valid.
//   -> then start A=3, B=3 gives igual=1 after 9 cycles.
//  Back-to-back: start held high:
//   -> each DONE cycle reloads; valid pulses once per compare.
//   -> flags correct for each new operand pair.

Source files
------------

// File: rtl/comparador_serial_izq_der_if.sv
// Handshake and operand bundle for the MSB-first serial magnitude comparator.
// The requester (master) drives start and the operands; the comparator (slave)
// returns status, the one-hot relation flags and the number of bits examined.
interface comparador_serial_izq_der_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             valid;
  logic             menor;
  logic             igual;
  logic             mayor;
  logic [CW-1:0]    ciclos;

  modport master (
    output start, A, B,
    input  busy, valid, menor, igual, mayor, ciclos
  );

  modport slave (
    input  start, A, B,
    output busy, valid, menor, igual, mayor, ciclos
  );
endinterface

// File: rtl/comparador_serial_izq_der.sv
// Bit-serial unsigned magnitude comparator scanning from MSB to LSB.
// Operands are captured on an accepted start and one bit pair is examined per
// clock. The first differing bit decides the relation for good; with
// EARLY_EXIT the scan stops there, otherwise all WIDTH bits are walked so the
// latency is constant. Results stay on the flags until the next accepted start.
module comparador_serial_izq_der #(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  comparador_serial_izq_der_if.slave   bus
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REL_EQ = 2'd0,
    REL_LT = 2'd1,
    REL_GT = 2'd2
  } rel_t;

  state_t           state_r;
  rel_t             rel_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [CW-1:0]    cnt_r;

  logic             a_bit_s;
  logic             b_bit_s;
  logic             differ_s;
  rel_t             rel_next_s;
  logic             finish_s;

  // Current MSB pair, relation after this bit and whether the scan ends now.
  always_comb begin
    a_bit_s    = a_sh_r[WIDTH-1];
    b_bit_s    = b_sh_r[WIDTH-1];
    differ_s   = a_bit_s ^ b_bit_s;
    rel_next_s = rel_r;
    if ((rel_r == REL_EQ) && differ_s) begin
      rel_next_s = a_bit_s ? REL_GT : REL_LT;
    end else begin
      rel_next_s = rel_r;
    end
    if (cnt_r == CNT_LAST) begin
      finish_s = 1'b1;
    end else if ((EARLY_EXIT != 0) && differ_s && (rel_r == REL_EQ)) begin
      finish_s = 1'b1;
    end else begin
      finish_s = 1'b0;
    end
  end

  // Control FSM with datapath shift registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      rel_r      <= REL_EQ;
      a_sh_r     <= '0;
      b_sh_r     <= '0;
      cnt_r      <= '0;
      bus.busy   <= 1'b0;
      bus.valid  <= 1'b0;
      bus.menor  <= 1'b0;
      bus.igual  <= 1'b0;
      bus.mayor  <= 1'b0;
      bus.ciclos <= '0;
    end else begin
      bus.valid <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            a_sh_r    <= bus.A;
            b_sh_r    <= bus.B;
            cnt_r     <= '0;
            rel_r     <= REL_EQ;
            bus.menor <= 1'b0;
            bus.igual <= 1'b0;
            bus.mayor <= 1'b0;
            bus.busy  <= 1'b1;
            state_r   <= ST_COMPARE;
          end else begin
            bus.busy  <= 1'b0;
            state_r   <= ST_IDLE;
          end
        end
        ST_COMPARE: begin
          a_sh_r <= {a_sh_r[WIDTH-2:0], 1'b0};
          b_sh_r <= {b_sh_r[WIDTH-2:0], 1'b0};
          cnt_r  <= cnt_r + CNT_ONE;
          rel_r  <= rel_next_s;
          if (finish_s) begin
            bus.menor  <= (rel_next_s == REL_LT);
            bus.igual  <= (rel_next_s == REL_EQ);
            bus.mayor  <= (rel_next_s == REL_GT);
            bus.ciclos <= cnt_r + CNT_ONE;
            bus.valid  <= 1'b1;
            bus.busy   <= 1'b0;
            state_r    <= ST_DONE;
          end else begin
            bus.busy   <= 1'b1;
            state_r    <= ST_COMPARE;
          end
        end
        default: begin
          bus.busy <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
